// File: rtl/fifo_wr_arbiter_if.sv
// Two-source write bus into the frame FIFO: source beat handshakes, FIFO write
// port and arbiter status. The arbiter uses the master view, the environment the slave view.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  s0_valid;
  logic                  s0_sof;
  logic                  s0_eof;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_ready;
  logic                  s1_valid;
  logic                  s1_sof;
  logic                  s1_eof;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_ready;
  logic                  wr_en;
  logic                  wr_sof;
  logic                  wr_eof;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  busy;
  logic                  owner;
  logic                  trunc;
  logic [1:0]            orphan;

  modport master (
    input  s0_valid, s0_sof, s0_eof, s0_data,
    input  s1_valid, s1_sof, s1_eof, s1_data,
    input  full,
    output s0_ready, s1_ready,
    output wr_en, wr_sof, wr_eof, din,
    output busy, owner, trunc, orphan
  );

  modport slave (
    output s0_valid, s0_sof, s0_eof, s0_data,
    output s1_valid, s1_sof, s1_eof, s1_data,
    output full,
    input  s0_ready, s1_ready,
    input  wr_en, wr_sof, wr_eof, din,
    input  busy, owner, trunc, orphan
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin merge of two byte-stream sources into the FIFO
// write port; frames stay whole, overlong frames are cut, stray beats dropped.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1024
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.master  bus
);
  localparam int              LEN_W     = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(MAX_FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t           state;
  logic             owner_q;
  logic             last_gnt;
  logic [LEN_W-1:0] len;
  logic             trunc_q;
  logic [1:0]       orphan_q;

  logic                  own_valid;
  logic                  own_sof;
  logic                  own_eof;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  cand0;
  logic                  cand1;
  logic                  gnt;
  logic                  orphan0;
  logic                  orphan1;
  logic                  at_limit;
  logic                  wr;
  logic [1:0]            rdy;

  assign own_valid = owner_q ? bus.s1_valid : bus.s0_valid;
  assign own_sof   = owner_q ? bus.s1_sof   : bus.s0_sof;
  assign own_eof   = owner_q ? bus.s1_eof   : bus.s0_eof;
  assign own_data  = owner_q ? bus.s1_data  : bus.s0_data;

  assign cand0   = bus.s0_valid & bus.s0_sof;
  assign cand1   = bus.s1_valid & bus.s1_sof;
  // On a tie the port that did not finish the previous frame wins.
  assign gnt     = (cand0 & cand1) ? ~last_gnt : cand1;
  // Orphan readies are the only combinational path from valid; gate them so
  // every output is quiet while reset is held.
  assign orphan0 = ~reset & bus.s0_valid & ~bus.s0_sof;
  assign orphan1 = ~reset & bus.s1_valid & ~bus.s1_sof;

  assign at_limit = (len == LAST_BEAT);
  assign wr       = (state == PASS) & own_valid & ~bus.full;

  always_comb begin
    rdy = 2'b00;
    unique case (state)
      IDLE:    rdy = {orphan1, orphan0};
      PASS:    rdy[owner_q] = ~bus.full;
      DROP:    rdy[owner_q] = 1'b1;
      default: rdy = 2'b00;
    endcase
  end

  assign bus.s0_ready = rdy[0];
  assign bus.s1_ready = rdy[1];
  assign bus.wr_en    = wr;
  assign bus.din      = wr ? own_data : '0;
  assign bus.wr_sof   = wr & own_sof;
  assign bus.wr_eof   = wr & (own_eof | at_limit);
  assign bus.busy     = (state != IDLE);
  assign bus.owner    = owner_q;
  assign bus.trunc    = trunc_q;
  assign bus.orphan   = orphan_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= 1'b0;
      last_gnt <= 1'b1;
      len      <= '0;
      trunc_q  <= 1'b0;
      orphan_q <= 2'b00;
    end else begin
      trunc_q  <= 1'b0;
      orphan_q <= 2'b00;
      unique case (state)
        IDLE: begin
          orphan_q <= {orphan1, orphan0};
          if (cand0 | cand1) begin
            owner_q <= gnt;
            len     <= '0;
            state   <= PASS;
          end
        end
        PASS: begin
          if (wr) begin
            len <= len + 1'b1;
            if (own_eof) begin
              last_gnt <= owner_q;
              state    <= IDLE;
            end else if (at_limit) begin
              // Written beat already carried the forced EOF; swallow the rest.
              trunc_q <= 1'b1;
              state   <= DROP;
            end
          end
        end
        DROP: begin
          if (own_valid & own_eof) begin
            last_gnt <= owner_q;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: instance 0 uses the default frame limit, instance 1
// a limit of 4; directed frames plus randomized traffic against a frame-level model.
module tb_fifo_wr_arbiter;
  logic clk;
  logic reset;

  logic [1:0] sv   [2];
  logic [1:0] ssof [2];
  logic [1:0] seof [2];
  logic [7:0] sd   [2][2];
  logic       full_v [2];
  wire  [17:0] obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();
    fifo_wr_arbiter #(
      .DATA_WIDTH   (8),
      .MAX_FRAME_LEN(g == 0 ? 1024 : 4)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.s0_valid = sv[g][0];
    assign bus.s0_sof   = ssof[g][0];
    assign bus.s0_eof   = seof[g][0];
    assign bus.s0_data  = sd[g][0];
    assign bus.s1_valid = sv[g][1];
    assign bus.s1_sof   = ssof[g][1];
    assign bus.s1_eof   = seof[g][1];
    assign bus.s1_data  = sd[g][1];
    assign bus.full     = full_v[g];
    assign obs[g] = {bus.s1_ready, bus.s0_ready, bus.wr_en, bus.wr_sof, bus.wr_eof,
                     bus.din, bus.busy, bus.owner, bus.trunc, bus.orphan};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Sources: queue of {sof, eof, data} per (instance*2 + port)
  logic [9:0] srcq [4][$];
  logic       pres [4];
  bit         gaps = 0;
  bit         full_rnd = 0;
  logic       full_force [2];

  // Reference model state: a frame is either unlocked (-1) or locked to a port.
  int         maxlen [2] = '{1024, 4};
  int         m_lock [2];
  bit         m_discard [2];
  int         m_beats [2];
  int         m_prev [2];
  int         m_shown [2];
  logic       m_trunc_q [2];
  logic [1:0] m_orph_q [2];
  logic [1:0] acc [2];

  logic [9:0] log_q [2][$];
  logic [9:0] exp_q [$];
  int busy_cnt [2];
  int trunc_cnt [2];
  int orph0_cnt [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = -1; m_discard[k] = 0; m_beats[k] = 0; m_prev[k] = 1;
      m_shown[k] = 0; m_trunc_q[k] = 1'b0; m_orph_q[k] = 2'b00;
    end
  endtask

  task automatic clear_sources();
    for (int s = 0; s < 4; s++) begin
      srcq[s].delete();
      pres[s] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      sv[k] = 2'b00; ssof[k] = 2'b00; seof[k] = 2'b00;
      sd[k][0] = 8'h00; sd[k][1] = 8'h00;
      full_v[k] = 1'b0; full_force[k] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        int s = k * 2 + p;
        if (!pres[s] && srcq[s].size() > 0 && (!gaps || $urandom_range(0, 2) != 0))
          pres[s] = 1'b1;
        sv[k][p] = pres[s];
        {ssof[k][p], seof[k][p], sd[k][p]} = pres[s] ? srcq[s][0] : 10'd0;
      end
      full_v[k] = full_rnd ? ($urandom_range(0, 4) == 0) : full_force[k];
    end
  endtask

  task automatic model_step(input int k);
    logic [1:0] e_rdy;
    logic [1:0] e_orph;
    logic       e_wen, e_sof, e_eof, e_busy, e_own, e_trn;
    logic [7:0] e_din;
    int p;
    int w;
    e_rdy = 2'b00; e_wen = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_din = 8'h00;
    e_orph = m_orph_q[k];
    e_busy = (m_lock[k] >= 0);
    e_own  = (m_shown[k] == 1);
    e_trn  = m_trunc_q[k];
    m_trunc_q[k] = 1'b0;
    m_orph_q[k]  = 2'b00;
    if (m_lock[k] < 0) begin
      for (int i = 0; i < 2; i++)
        if (sv[k][i] && !ssof[k][i]) begin
          e_rdy[i] = 1'b1;
          m_orph_q[k][i] = 1'b1;
        end
      if (sv[k][0] && ssof[k][0] && sv[k][1] && ssof[k][1]) w = 1 - m_prev[k];
      else if (sv[k][0] && ssof[k][0]) w = 0;
      else if (sv[k][1] && ssof[k][1]) w = 1;
      else w = -1;
      if (w >= 0) begin
        m_lock[k] = w; m_shown[k] = w; m_discard[k] = 0; m_beats[k] = 0;
      end
    end else begin
      p = m_lock[k];
      if (m_discard[k]) begin
        e_rdy[p] = 1'b1;
        if (sv[k][p] && seof[k][p]) begin
          m_lock[k] = -1; m_prev[k] = p;
        end
      end else if (!full_v[k]) begin
        e_rdy[p] = 1'b1;
        if (sv[k][p]) begin
          m_beats[k]++;
          e_wen = 1'b1;
          e_din = sd[k][p];
          e_sof = ssof[k][p];
          e_eof = seof[k][p] || (m_beats[k] == maxlen[k]);
          if (seof[k][p]) begin
            m_lock[k] = -1; m_prev[k] = p;
          end else if (m_beats[k] == maxlen[k]) begin
            m_discard[k] = 1; m_trunc_q[k] = 1'b1;
          end
        end
      end
    end
    acc[k] = sv[k] & e_rdy;
    chk($sformatf("cycle%0d_inst%0d", cyc, k), 32'(obs[k]),
        32'({e_rdy, e_wen, e_sof, e_eof, e_din, e_busy, e_own, e_trn, e_orph}));
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    for (int k = 0; k < 2; k++) model_step(k);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++)
        if (acc[k][p]) begin
          srcq[k * 2 + p].delete(0);
          pres[k * 2 + p] = 1'b0;
        end
      if (obs[k][15]) log_q[k].push_back({obs[k][14], obs[k][13], obs[k][12:5]});
      if (obs[k][4]) busy_cnt[k]++;
      if (obs[k][2]) trunc_cnt[k]++;
      if (obs[k][1:0] == 2'b01) orph0_cnt[k]++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    drive();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("%s_inst%0d", tag, k), 32'(obs[k]), 32'd0);
    clear_sources();
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic begin_test();
    for (int k = 0; k < 2; k++) begin
      log_q[k].delete();
      busy_cnt[k] = 0; trunc_cnt[k] = 0; orph0_cnt[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic frame(input int k, input int p, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++)
      srcq[k * 2 + p].push_back({i == 0, i == n - 1, 8'(first + i)});
  endtask

  task automatic exp_frame(input logic [7:0] first, input int n, input int lim);
    int m;
    m = (n < lim) ? n : lim;
    for (int i = 0; i < m; i++)
      exp_q.push_back({i == 0, (i == n - 1) || (i == lim - 1), 8'(first + i)});
  endtask

  task automatic check_log(input int k, input string tag);
    chk({tag, "_count"}, log_q[k].size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q[k].size())
        chk($sformatf("%s_beat%0d", tag, i), 32'(log_q[k][i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset = 1'b0;
    clear_sources();
    model_reset();
    #1 reset = 1'b1;
    // Live orphan and SOF inputs while reset is held must not leak to outputs.
    sv[0] = 2'b11; ssof[0] = 2'b10; sd[0][0] = 8'hAA; sd[0][1] = 8'h55;
    sv[1] = 2'b01; ssof[1] = 2'b00;
    #2;
    chk("reset_outputs_inst0", 32'(obs[0]), 32'd0);
    chk("reset_outputs_inst1", 32'(obs[1]), 32'd0);
    clear_sources();
    #9 reset = 1'b0;

    // Single 4-beat frame from port 0
    begin_test();
    frame(0, 0, 8'h11, 4);
    exp_frame(8'h11, 4, 1024);
    run(8);
    check_log(0, "frame4");
    chk("frame4_busy_cycles", busy_cnt[0], 4);
    chk("frame4_other_inst_quiet", log_q[1].size(), 0);

    // Simultaneous SOF from both ports, twice
    do_reset("reset_before_tie");
    begin_test();
    frame(0, 0, 8'h21, 3); frame(0, 1, 8'h31, 3);
    frame(0, 0, 8'h24, 3); frame(0, 1, 8'h34, 3);
    exp_frame(8'h21, 3, 1024); exp_frame(8'h31, 3, 1024);
    exp_frame(8'h24, 3, 1024); exp_frame(8'h34, 3, 1024);
    run(20);
    check_log(0, "tie");

    // Truncation with limit 4 on instance 1
    begin_test();
    frame(1, 1, 8'h41, 6);
    exp_frame(8'h41, 6, 4);
    run(10);
    check_log(1, "trunc");
    chk("trunc_pulses", trunc_cnt[1], 1);
    chk("trunc_tail_consumed", srcq[3].size(), 0);

    // Orphan beat in IDLE
    begin_test();
    srcq[0].push_back({1'b0, 1'b0, 8'hAA});
    run(4);
    chk("orphan_no_write", log_q[0].size(), 0);
    chk("orphan_pulses", orph0_cnt[0], 1);
    chk("orphan_consumed", srcq[0].size(), 0);

    // FIFO full for 3 cycles mid-frame
    begin_test();
    frame(0, 0, 8'h51, 8);
    exp_frame(8'h51, 8, 1024);
    for (int i = 0; i < 15; i++) begin
      full_force[0] = (i >= 3 && i < 6);
      cycle();
    end
    full_force[0] = 1'b0;
    check_log(0, "full_stall");

    // Reset during beat 3 of a 5-beat frame, then a port 1 frame
    begin_test();
    frame(0, 0, 8'h61, 5);
    run(3);
    do_reset("reset_mid_frame");
    begin_test();
    frame(0, 1, 8'h71, 3);
    exp_frame(8'h71, 3, 1024);
    run(8);
    check_log(0, "after_reset");

    // Randomized traffic on both instances
    begin_test();
    gaps = 1;
    full_rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int s = 0; s < 4; s++)
        if (srcq[s].size() == 0 && $urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 7) == 0)
            srcq[s].push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
          else begin
            int n = $urandom_range(1, 7);
            for (int b = 0; b < n; b++)
              srcq[s].push_back({b == 0, b == n - 1, 8'($urandom)});
          end
        end
      cycle();
    end
    gaps = 0;
    full_rnd = 0;
    run(60);
    for (int s = 0; s < 4; s++) chk($sformatf("random_drained_src%0d", s), srcq[s].size(), 0);
    chk("random_writes_inst0", 32'(log_q[0].size() > 0), 32'd1);
    chk("random_writes_inst1", 32'(log_q[1].size() > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
